// File: rtl/noc_pkg.sv
// Shared flit layout, routing decision and two-way round-robin helper for the ring NoC.
package noc_pkg;

    localparam int FLIT_W    = 16;
    localparam int DEST_W    = 6;
    localparam int PAYLOAD_W = 10;
    localparam int DEST_MSB  = 15;
    localparam int DEST_LSB  = 10;

    typedef enum logic [1:0] {
        ROUTE_EJECT,
        ROUTE_RING,
        ROUTE_DROP
    } route_e;

    // Grant pair and updated priority bit produced by one output's arbiter.
    typedef struct packed {
        logic gnt_a;
        logic gnt_b;
        logic rr_next;
    } arb_t;

    // Local dest ejects, any other in-range dest continues on the ring,
    // out-of-range dest is unroutable and gets dropped.
    function automatic route_e route_of(input logic [DEST_W-1:0] dest,
                                        input int node_id,
                                        input int num_nodes);
        int d;
        d = 32'(dest);
        if (d == node_id) begin
            return ROUTE_EJECT;
        end
        if (d < num_nodes) begin
            return ROUTE_RING;
        end
        return ROUTE_DROP;
    endfunction

    // rr=0 favours side a (ring input). A contested grant flips the priority;
    // an uncontested grant leaves it alone. Nothing is granted while the
    // output slot cannot load.
    function automatic arb_t rr_arbitrate(input logic req_a,
                                          input logic req_b,
                                          input logic rr,
                                          input logic can_load);
        arb_t r;
        r.gnt_a   = 1'b0;
        r.gnt_b   = 1'b0;
        r.rr_next = rr;
        if (can_load) begin
            if (req_a && req_b) begin
                r.gnt_a   = !rr;
                r.gnt_b   = rr;
                r.rr_next = !rr;
            end else begin
                r.gnt_a = req_a;
                r.gnt_b = req_b;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with valid/ready on both sides; pointers carry a wrap bit
// so full and empty are told apart without a separate counter.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FLIT_W
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Write storage on push.
    always_ff @(posedge ACLK) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

endmodule

// File: rtl/noc_ring_node.sv
// Ring NoC node: buffers ring and local-inject flits, routes each FIFO head to the
// eject port, the downstream ring or the drop counter, and arbitrates each output
// round-robin between the two inputs.
module noc_ring_node
    import noc_pkg::*;
#(
    parameter int NODE_ID    = 0,
    parameter int NUM_NODES  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [FLIT_W-1:0] inj_data,
    input  logic              inj_valid,
    output logic              inj_ready,
    input  logic [FLIT_W-1:0] ring_in_data,
    input  logic              ring_in_valid,
    output logic              ring_in_ready,
    output logic [FLIT_W-1:0] ring_out_data,
    output logic              ring_out_valid,
    input  logic              ring_out_ready,
    output logic [FLIT_W-1:0] ej_data,
    output logic              ej_valid,
    input  logic              ej_ready,
    output logic [15:0]       drop_count
);

    // Side a of each arbiter is the ring FIFO (rf), side b the inject FIFO (jf).
    logic [FLIT_W-1:0] rf_data, jf_data;
    logic              rf_valid, jf_valid;
    logic              rf_pop, jf_pop;
    logic              rf_drop, jf_drop;
    route_e            rf_route, jf_route;
    arb_t              ring_arb, ej_arb;
    logic              ring_rr, ej_rr;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;

    noc_flit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FLIT_W)) u_ring_fifo (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .in_data  (ring_in_data),
        .in_valid (ring_in_valid),
        .in_ready (ring_in_ready),
        .out_data (rf_data),
        .out_valid(rf_valid),
        .out_ready(rf_pop)
    );

    noc_flit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FLIT_W)) u_inj_fifo (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .in_data  (inj_data),
        .in_valid (inj_valid),
        .in_ready (inj_ready),
        .out_data (jf_data),
        .out_valid(jf_valid),
        .out_ready(jf_pop)
    );

    assign rf_route = route_of(rf_data[DEST_MSB:DEST_LSB], NODE_ID, NUM_NODES);
    assign jf_route = route_of(jf_data[DEST_MSB:DEST_LSB], NODE_ID, NUM_NODES);

    // A slot may load when empty or when its current flit leaves this cycle.
    assign ring_arb = rr_arbitrate(rf_valid && (rf_route == ROUTE_RING),
                                   jf_valid && (jf_route == ROUTE_RING),
                                   ring_rr, !ring_out_valid || ring_out_ready);
    assign ej_arb   = rr_arbitrate(rf_valid && (rf_route == ROUTE_EJECT),
                                   jf_valid && (jf_route == ROUTE_EJECT),
                                   ej_rr, !ej_valid || ej_ready);

    // Dropped heads leave without arbitration.
    assign rf_drop = rf_valid && (rf_route == ROUTE_DROP);
    assign jf_drop = jf_valid && (jf_route == ROUTE_DROP);
    assign rf_pop  = rf_drop || ring_arb.gnt_a || ej_arb.gnt_a;
    assign jf_pop  = jf_drop || ring_arb.gnt_b || ej_arb.gnt_b;

    assign drop_inc = {1'b0, rf_drop} + {1'b0, jf_drop};
    assign drop_sum = {1'b0, drop_count} + {15'd0, drop_inc};

    // Ring output slot: load the granted head, hold while stalled.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ring_out_valid <= 1'b0;
            ring_out_data  <= '0;
        end else if (!ring_out_valid || ring_out_ready) begin
            ring_out_valid <= ring_arb.gnt_a || ring_arb.gnt_b;
            if (ring_arb.gnt_a)      ring_out_data <= rf_data;
            else if (ring_arb.gnt_b) ring_out_data <= jf_data;
        end
    end

    // Eject output slot: same loading rule as the ring slot.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ej_valid <= 1'b0;
            ej_data  <= '0;
        end else if (!ej_valid || ej_ready) begin
            ej_valid <= ej_arb.gnt_a || ej_arb.gnt_b;
            if (ej_arb.gnt_a)      ej_data <= rf_data;
            else if (ej_arb.gnt_b) ej_data <= jf_data;
        end
    end

    // Round-robin priority bits; reset favours the ring input.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ring_rr <= 1'b0;
            ej_rr   <= 1'b0;
        end else begin
            ring_rr <= ring_arb.rr_next;
            ej_rr   <= ej_arb.rr_next;
        end
    end

    // Saturating drop counter, up to two drops per cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_noc_ring_node.sv
// Self-checking bench for noc_ring_node: per-source scoreboards fed at input
// handshakes and consumed at output handshakes, plus directed latency,
// fairness, backpressure, drop-saturation and reset checks.
module tb_noc_ring_node;
    import noc_pkg::*;

    localparam int NODE_ID    = 30;
    localparam int NUM_NODES  = 32;
    localparam int FIFO_DEPTH = 4;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [15:0] inj_data, ring_in_data;
    logic        inj_valid, ring_in_valid;
    logic        inj_ready, ring_in_ready;
    logic [15:0] ring_out_data, ej_data;
    logic        ring_out_valid, ej_valid;
    logic        ring_out_ready, ej_ready;
    logic [15:0] drop_count;

    noc_ring_node #(.NODE_ID(NODE_ID), .NUM_NODES(NUM_NODES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .inj_data      (inj_data),
        .inj_valid     (inj_valid),
        .inj_ready     (inj_ready),
        .ring_in_data  (ring_in_data),
        .ring_in_valid (ring_in_valid),
        .ring_in_ready (ring_in_ready),
        .ring_out_data (ring_out_data),
        .ring_out_valid(ring_out_valid),
        .ring_out_ready(ring_out_ready),
        .ej_data       (ej_data),
        .ej_valid      (ej_valid),
        .ej_ready      (ej_ready),
        .drop_count    (drop_count)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Expected flits per (output, source); drop model; ring_out source log (0 ring, 1 inject).
    logic [15:0] q_ring_r[$], q_ring_j[$], q_ej_r[$], q_ej_j[$];
    int          exp_drops = 0;
    int          src_log[$];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] exp_drop_count();
        return (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
    endfunction

    task automatic sb_push(input logic [15:0] d, input bit from_inj);
        int dest;
        dest = 32'(d[15:10]);
        if (dest == NODE_ID) begin
            if (from_inj) q_ej_j.push_back(d); else q_ej_r.push_back(d);
        end else if (dest < NUM_NODES) begin
            if (from_inj) q_ring_j.push_back(d); else q_ring_r.push_back(d);
        end else begin
            exp_drops++;
        end
    endtask

    task automatic sb_pop_ring(input logic [15:0] d);
        logic [15:0] exp;
        if (q_ring_r.size() > 0 && q_ring_r[0] == d) begin
            exp = q_ring_r.pop_front();
            src_log.push_back(0);
            check("ring_out_data", d, exp);
        end else if (q_ring_j.size() > 0) begin
            exp = q_ring_j.pop_front();
            src_log.push_back(1);
            check("ring_out_data", d, exp);
        end else begin
            check("ring_out_unexpected", 32'(d), 32'hFFFF_FFFF);
        end
    endtask

    task automatic sb_pop_ej(input logic [15:0] d);
        logic [15:0] exp;
        if (q_ej_r.size() > 0 && q_ej_r[0] == d) begin
            exp = q_ej_r.pop_front();
            check("ej_data", d, exp);
        end else if (q_ej_j.size() > 0) begin
            exp = q_ej_j.pop_front();
            check("ej_data", d, exp);
        end else begin
            check("ej_unexpected", 32'(d), 32'hFFFF_FFFF);
        end
    endtask

    // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (ring_in_valid && ring_in_ready)   sb_push(ring_in_data, 1'b0);
            if (inj_valid && inj_ready)           sb_push(inj_data, 1'b1);
            if (ring_out_valid && ring_out_ready) sb_pop_ring(ring_out_data);
            if (ej_valid && ej_ready)             sb_pop_ej(ej_data);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic send_one(input bit to_inj, input logic [15:0] d);
        bit hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (to_inj) begin inj_valid = 1'b1; inj_data = d; end
            else begin ring_in_valid = 1'b1; ring_in_data = d; end
            @(negedge ACLK);
            hit = to_inj ? inj_ready : ring_in_ready;
            @(posedge ACLK);
            #1;
        end
        inj_valid     = 1'b0;
        ring_in_valid = 1'b0;
        check("send_accepted", 32'(hit), 1);
    endtask

    // Drive nr ring flits and nj inject flits concurrently, advancing on each accept.
    task automatic stream(input int nr, input int nj, input logic [5:0] rd, input logic [5:0] jd, input int max_cyc);
        int ri = 0;
        int ji = 0;
        bit rh, jh;
        for (int c = 0; c < max_cyc && (ri < nr || ji < nj); c++) begin
            ring_in_valid = (ri < nr);
            ring_in_data  = {rd, 10'(32'h100 + ri)};
            inj_valid     = (ji < nj);
            inj_data      = {jd, 10'(32'h200 + ji)};
            @(negedge ACLK);
            rh = ring_in_valid && ring_in_ready;
            jh = inj_valid && inj_ready;
            @(posedge ACLK);
            #1;
            if (rh) ri++;
            if (jh) ji++;
        end
        ring_in_valid = 1'b0;
        inj_valid     = 1'b0;
        check("stream_complete", 32'(ri + ji), 32'(nr + nj));
    endtask

    task automatic wait_drain(input int bound);
        int c = 0;
        while ((q_ring_r.size() + q_ring_j.size() + q_ej_r.size() + q_ej_j.size() > 0
                || ring_out_valid || ej_valid) && c < bound) begin
            tick(1);
            c++;
        end
        check("drain_in_time", 32'(c < bound), 1);
        tick(2);
    endtask

    initial begin
        ARESET         = 1'b1;
        inj_data       = '0;
        inj_valid      = 1'b0;
        ring_in_data   = '0;
        ring_in_valid  = 1'b0;
        ring_out_ready = 1'b1;
        ej_ready       = 1'b1;
        tick(3);
        ARESET = 1'b0;

        // Reset state.
        check("rst_inj_ready", 32'(inj_ready), 1);
        check("rst_ring_in_ready", 32'(ring_in_ready), 1);
        check("rst_ring_out_valid", 32'(ring_out_valid), 0);
        check("rst_ej_valid", 32'(ej_valid), 0);
        check("rst_ring_out_data", 32'(ring_out_data), 0);
        check("rst_ej_data", 32'(ej_data), 0);
        check("rst_drop_count", 32'(drop_count), 0);

        // Inject to dest 31: ring_out valid two edges after the accept edge counted as first.
        send_one(1'b1, 16'h7D23);
        check("lat_ring_not_yet", 32'(ring_out_valid), 0);
        tick(1);
        check("lat_ring_valid", 32'(ring_out_valid), 1);
        check("lat_ring_data", 32'(ring_out_data), 32'h7D23);
        check("lat_ej_idle", 32'(ej_valid), 0);
        wait_drain(20);

        // Ring-in to dest 30: ejected locally, ring_out untouched.
        send_one(1'b0, 16'h7923);
        check("ej_not_yet", 32'(ej_valid), 0);
        tick(1);
        check("ej_valid", 32'(ej_valid), 1);
        check("ej_data_lat", 32'(ej_data), 32'h7923);
        check("ej_ring_idle", 32'(ring_out_valid), 0);
        wait_drain(20);

        // Inject to self (GPU loopback) goes to eject.
        send_one(1'b1, 16'h7801);
        wait_drain(20);

        // Fairness: both inputs stream dest-31 flits; ring_out alternates starting with ring.
        src_log.delete();
        stream(8, 8, 6'd31, 6'd31, 200);
        wait_drain(100);
        check("fair_count", 32'(src_log.size()), 16);
        for (int k = 0; k < src_log.size() && k < 16; k++) begin
            check($sformatf("fair_src_%0d", k), 32'(src_log[k]), 32'(k % 2));
        end

        // Different outputs serve both heads concurrently, order preserved per input.
        stream(4, 4, 6'd30, 6'd5, 100);
        wait_drain(100);

        // Backpressure: ring_out stalled, 6 offered, exactly 5 accepted.
        begin
            int acc = 0;
            bit hit;
            ring_out_ready = 1'b0;
            for (int c = 0; c < 10 && acc < 6; c++) begin
                inj_valid = 1'b1;
                inj_data  = {6'd31, 10'(32'h300 + acc)};
                @(negedge ACLK);
                hit = inj_ready;
                @(posedge ACLK);
                #1;
                if (hit) acc++;
            end
            inj_valid = 1'b0;
            check("bp_accepts", 32'(acc), 5);
            check("bp_inj_ready_low", 32'(inj_ready), 0);
            check("bp_ring_out_held", 32'(ring_out_data), 32'h7F00);
            ring_out_ready = 1'b1;
            wait_drain(50);
        end

        // Drop: dest 63 produces no output and counts once.
        send_one(1'b1, 16'hFC11);
        tick(3);
        check("drop_no_ring", 32'(ring_out_valid), 0);
        check("drop_no_ej", 32'(ej_valid), 0);
        check("drop_count_1", 32'(drop_count), 32'(exp_drop_count()));
        check("drop_model_1", 32'(exp_drops), 1);

        // Double drops per cycle up to and past saturation.
        stream(32768, 32768, 6'h3F, 6'h3F, 40000);
        tick(4);
        check("drop_saturated", 32'(drop_count), 32'(exp_drop_count()));
        send_one(1'b0, 16'hFC22);
        tick(3);
        check("drop_stays_max", 32'(drop_count), 32'hFFFF);

        // Reset mid-operation with buffered flits and ej_valid high.
        ring_out_ready = 1'b0;
        ej_ready       = 1'b0;
        send_one(1'b1, 16'h7C01);
        send_one(1'b1, 16'h7C02);
        send_one(1'b1, 16'h7C03);
        send_one(1'b0, 16'h7855);
        tick(3);
        check("pre_rst_ej_valid", 32'(ej_valid), 1);
        ARESET = 1'b1;
        tick(1);
        ARESET = 1'b0;
        q_ring_r.delete();
        q_ring_j.delete();
        q_ej_r.delete();
        q_ej_j.delete();
        exp_drops = 0;
        check("mid_rst_ring_out_valid", 32'(ring_out_valid), 0);
        check("mid_rst_ej_valid", 32'(ej_valid), 0);
        check("mid_rst_inj_ready", 32'(inj_ready), 1);
        check("mid_rst_ring_in_ready", 32'(ring_in_ready), 1);
        check("mid_rst_drop_count", 32'(drop_count), 0);
        ring_out_ready = 1'b1;
        ej_ready       = 1'b1;
        tick(3);
        check("post_rst_no_stale", 32'(ring_out_valid), 0);

        // Node still works after reset.
        send_one(1'b1, 16'h7D23);
        wait_drain(20);

        check("end_q_ring_r", 32'(q_ring_r.size()), 0);
        check("end_q_ring_j", 32'(q_ring_j.size()), 0);
        check("end_q_ej_r", 32'(q_ej_r.size()), 0);
        check("end_q_ej_j", 32'(q_ej_j.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
